// File: rtl/wave_table_writer.sv
`default_nettype none
// ============================================================================
// Module      : wave_table_writer
// Description : Loads a waveform table into the generator's sample RAM. Bytes
//               arrive over a valid/ready handshake, are packed in pairs
//               (low byte first) into DATA_W-bit samples and written at
//               sequential addresses 0..len. On completion the table's last
//               address is published as the playback wrap point.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   single-cycle load request, sampled only when idle
//   len        in   last address to write (samples - 1), captured on start
//   in_data    in   stream byte
//   in_valid   in   stream byte valid
//   in_ready   out  writer accepts a byte this cycle
//   we         out  RAM write strobe, one cycle per sample
//   waddr      out  RAM write address
//   wdata      out  RAM write data
//   busy       out  load in progress
//   done       out  one-cycle pulse after the final write
//   last_addr  out  playback wrap address, updated only at done
// ============================================================================
module wave_table_writer #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] last_addr
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LO   = 3'd1,
        S_HI   = 3'd2,
        S_WR   = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [7:0]        lo_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-1:0] last_addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            lo_q        <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            last_addr_q <= '1;   // full table until a load completes
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        len_q   <= len;
                        cnt_q   <= '0;
                        state_q <= S_LO;
                    end
                end
                S_LO: begin
                    // in_ready is 1 here, so in_valid alone is the handshake
                    if (in_valid) begin
                        lo_q    <= in_data;
                        state_q <= S_HI;
                    end
                end
                S_HI: begin
                    if (in_valid) begin
                        // Address and data are registered here so they are
                        // stable for the whole write cycle that follows.
                        waddr_q <= cnt_q;
                        wdata_q <= {in_data[DATA_W-9:0], lo_q};
                        state_q <= S_WR;
                    end
                end
                S_WR: begin
                    // Terminal compare before the increment: len = all-ones
                    // fills the RAM without the counter ever wrapping.
                    if (cnt_q == len_q) begin
                        last_addr_q <= len_q;
                        state_q     <= S_FIN;
                    end else begin
                        cnt_q   <= cnt_q + ADDR_W'(1);
                        state_q <= S_LO;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake and strobes come straight from the state register; nothing
    // here depends combinationally on in_valid.
    assign in_ready  = (state_q == S_LO) || (state_q == S_HI);
    assign we        = (state_q == S_WR);
    assign busy      = (state_q == S_LO) || (state_q == S_HI) || (state_q == S_WR);
    assign done      = (state_q == S_FIN);
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign last_addr = last_addr_q;

    // High-byte bits above the sample width are intentionally discarded.
    generate
        if (DATA_W < 16) begin : g_unused_hi
            logic w_unused_hi;
            assign w_unused_hi = ^in_data[7:DATA_W-8];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_wave_table_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_wave_table_writer
// Description : Self-checking bench for wave_table_writer. Byte streams are
//               compared against a reference built from the packing rule:
//               sample i = {byte[2i+1] low bits, byte[2i]} at address i.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wave_table_writer;

    localparam int AW = 12;
    localparam int DW = 12;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] len;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          busy;
    logic          done;
    logic [AW-1:0] last_addr;

    int checks   = 0;
    int failures = 0;

    logic [7:0] bq[$];

    wave_table_writer #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .last_addr (last_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic [AW-1:0] exp_last);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_we"}, we, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_last_addr"}, last_addr, exp_last);
    endtask

    // mode 0: continuous stream, 1: valid 1-in-5 with stray start pulses,
    // 2: random valid. abort_after >= 0 stops once that many bytes are taken.
    task automatic do_load(input int len_v, input int mode, input int abort_after);
        int         n;
        int         bi;
        int         wi;
        int         cyc;
        int         last_we;
        int         budget;
        logic       hs;
        logic       prev_we;
        logic [DW-1:0] exp_d;
        n = len_v + 1;
        while (bq.size() < 2 * n) bq.push_back(8'($urandom));
        start = 1'b1;
        len   = AW'(len_v);
        @(posedge clk); #1;
        start = 1'b0;
        len   = AW'($urandom);      // must not matter after acceptance
        check("busy_after_start", busy, 1);
        check("ready_after_start", in_ready, 1);
        bi = 0; wi = 0; cyc = 0; last_we = -10; prev_we = 1'b0;
        budget = 30 * n + 50;
        forever begin
            if (abort_after >= 0 && bi == abort_after) break;
            case (mode)
                0:       in_valid = (bi < 2 * n);
                1:       in_valid = (bi < 2 * n) && (cyc % 5 == 0);
                default: in_valid = (bi < 2 * n) && ($urandom_range(0, 2) != 0);
            endcase
            in_data = in_valid ? bq[bi] : 8'($urandom);
            if (mode == 1) begin
                start = ($urandom_range(0, 3) == 0);
                len   = AW'($urandom);
            end
            hs = in_valid & in_ready;
            @(posedge clk); #1;
            cyc++;
            if (hs) bi++;
            if (we) begin
                if (wi < n) begin
                    exp_d = DW'(((bq[2*wi+1] % (1 << (DW - 8))) * 256) + bq[2*wi]);
                    check("waddr", waddr, wi);
                    check("wdata", wdata, exp_d);
                end else begin
                    check("extra_write", 1, 0);
                end
                check("we_single_cycle", prev_we, 0);
                check("ready_during_we", in_ready, 0);
                if (mode == 0) check("we_cycle", cyc, 3 * wi + 2);
                last_we = cyc;
                wi++;
            end
            prev_we = we;
            if (done) begin
                start = 1'b0;
                check("write_count", wi, n);
                check("done_after_last_we", cyc - last_we, 1);
                check("busy_at_done", busy, 0);
                check("last_addr_at_done", last_addr, len_v);
                if (mode == 0) check("done_cycle", cyc, 3 * n);
                break;
            end
            if (abort_after < 0) check("busy_in_load", busy, 1);
            if (cyc > budget) begin
                check("timeout", 0, 1);
                break;
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
        if (abort_after < 0) begin
            @(posedge clk); #1;
            check_idle("post_load", AW'(len_v));
        end
        bq.delete();
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; len = '0; in_data = '0; in_valid = 1'b0;
        #1 rst = 1'b1;
        #2 check_idle("in_reset", '1);
        #3 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;            // valid while idle must not be consumed
            in_data  = 8'($urandom);
            @(posedge clk); #1;
            check_idle("after_reset", '1);
            check("waddr_reset", waddr, 0);
            check("wdata_reset", wdata, 0);
        end
        in_valid = 1'b0;

        // Directed back-to-back load of four samples
        bq = '{8'h34, 8'h12, 8'hCD, 8'h0A, 8'h00, 8'h0F, 8'hFF, 8'h00};
        do_load(3, 0, -1);

        // Single sample, upper nibble of the high byte discarded
        bq = '{8'h55, 8'hF7};
        do_load(0, 0, -1);

        // Stalled source with stray start pulses
        do_load(1, 1, -1);

        // Whole RAM
        do_load(4095, 0, -1);

        // Random lengths and random valid patterns
        for (int t = 0; t < 6; t++) begin
            do_load(int'($urandom_range(1, 20)), 2, -1);
        end

        // Reset during a load after the third byte
        do_load(5, 0, 3);
        #2 rst = 1'b1;
        #1 check_idle("mid_reset", '1);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check_idle("after_mid_reset", '1);
        do_load(1, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
